// File: rtl/act_pkg.sv
// Shared types and PLAN constants for the act_pipe activation unit.
// Breakpoints and offsets are stored as num / 2^sh so they scale to any fraction width.
package act_pkg;

   typedef enum logic [1:0] {
      ACT_SIGMOID = 2'b00,
      ACT_RELU    = 2'b01,
      ACT_TANH    = 2'b10,
      ACT_IDENT   = 2'b11
   } act_mode_e;

   // guard bits carried below the output LSB through the PLAN evaluation
   localparam int PLAN_GUARD = 6;

   localparam int BP_HI_NUM  = 5;   localparam int BP_HI_SH  = 0;   // 5.0
   localparam int BP_MID_NUM = 19;  localparam int BP_MID_SH = 3;   // 2.375
   localparam int BP_LO_NUM  = 1;   localparam int BP_LO_SH  = 0;   // 1.0

   localparam int SLOPE_HI_SH  = 5;
   localparam int SLOPE_MID_SH = 3;
   localparam int SLOPE_LO_SH  = 2;

   localparam int OFS_HI_NUM  = 27; localparam int OFS_HI_SH  = 5;  // 0.84375
   localparam int OFS_MID_NUM = 5;  localparam int OFS_MID_SH = 3;  // 0.625
   localparam int OFS_LO_NUM  = 1;  localparam int OFS_LO_SH  = 1;  // 0.5

   function automatic int int_frac(input int out_frac);
      return out_frac + PLAN_GUARD;
   endfunction

   function automatic int abs_w(input int in_w, input bit dbl);
      return in_w + (dbl ? 2 : 1);
   endfunction

   // num / 2^sh expressed with frac fraction bits
   function automatic int fx(input int num, input int sh, input int frac);
      return num << (frac - sh);
   endfunction

endpackage

// File: rtl/act_plan_seg.sv
// Piecewise-linear sigmoid core on a non-negative magnitude: segment select
// plus shift-add, result in [0.5, 1.0] with IFRAC fraction bits.
module act_plan_seg
   import act_pkg::*;
#(
   parameter int A_W     = 10,
   parameter int IN_FRAC = 4,
   parameter int IFRAC   = 12
) (
   input  logic [A_W-1:0] a,
   output logic [IFRAC:0] f
);

   localparam int F_W = IFRAC + 1;
   localparam int SH  = IFRAC - IN_FRAC;
   localparam int WW  = A_W + SH;

   localparam logic [A_W-1:0] BP_HI  = A_W'(fx(BP_HI_NUM,  BP_HI_SH,  IN_FRAC));
   localparam logic [A_W-1:0] BP_MID = A_W'(fx(BP_MID_NUM, BP_MID_SH, IN_FRAC));
   localparam logic [A_W-1:0] BP_LO  = A_W'(fx(BP_LO_NUM,  BP_LO_SH,  IN_FRAC));

   localparam logic [F_W-1:0] F_ONE   = F_W'(fx(1, 0, IFRAC));
   localparam logic [F_W-1:0] OFS_HI  = F_W'(fx(OFS_HI_NUM,  OFS_HI_SH,  IFRAC));
   localparam logic [F_W-1:0] OFS_MID = F_W'(fx(OFS_MID_NUM, OFS_MID_SH, IFRAC));
   localparam logic [F_W-1:0] OFS_LO  = F_W'(fx(OFS_LO_NUM,  OFS_LO_SH,  IFRAC));

   logic [WW-1:0] a_f;

   assign a_f = WW'(a) << SH;

   // below 5.0 every segment stays within [0.5, 1.0], so the narrowing is lossless
   always_comb begin
      f = '0;
      if (a >= BP_HI)
         f = F_ONE;
      else if (a >= BP_MID)
         f = F_W'(a_f >> SLOPE_HI_SH) + OFS_HI;
      else if (a >= BP_LO)
         f = F_W'(a_f >> SLOPE_MID_SH) + OFS_MID;
      else
         f = F_W'(a_f >> SLOPE_LO_SH) + OFS_LO;
   end

endmodule

// File: rtl/act_pipe.sv
// Three-stage activation pipeline (sigmoid/ReLU/tanh/identity) behind valid/ready.
// Define ACT_TANH_EN to build the true tanh path; otherwise mode 10 yields sigmoid.
module act_pipe
   import act_pkg::*;
#(
   parameter int IN_W     = 8,
   parameter int IN_FRAC  = 4,
   parameter int OUT_W    = 8,
   parameter int OUT_FRAC = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last
);

   localparam int IFRAC = int_frac(OUT_FRAC);
`ifdef ACT_TANH_EN
   localparam int A_W = abs_w(IN_W, 1'b1);
`else
   localparam int A_W = abs_w(IN_W, 1'b0);
`endif
   localparam int V_W = A_W + IFRAC - IN_FRAC + 2;
   localparam int RSH = IFRAC - OUT_FRAC;

   localparam logic signed [V_W-1:0] ONE    = V_W'(fx(1, 0, IFRAC));
   localparam logic signed [V_W-1:0] HALF   = V_W'(fx(1, 0, RSH - 1));
   localparam logic signed [V_W-1:0] SAT_HI = V_W'(fx(1, 0, OUT_W - 1) - 1);
   localparam logic signed [V_W-1:0] SAT_LO = ~SAT_HI;

   logic            en;
   logic [IN_W:0]   x_ext, mag;
   act_mode_e       mode_in;

   logic            s1_valid, s1_neg, s1_last;
   logic [A_W-1:0]  s1_a;
   act_mode_e       s1_mode;

   logic            s2_valid, s2_neg, s2_last;
   logic [A_W-1:0]  s2_a;
   logic [IFRAC:0]  s2_f;
   act_mode_e       s2_mode;
   logic [IFRAC:0]  plan_f;

   logic [V_W-1:0]        a_u;
   logic signed [V_W-1:0] a_v, f_v, sig_v, res, rnd, sat;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign mode_in  = act_mode_e'(in_mode);

   // one extra bit so |-2^(IN_W-1)| is exact
   assign x_ext = {in_data[IN_W-1], in_data};
   assign mag   = in_data[IN_W-1] ? (~x_ext + 1'b1) : x_ext;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_neg   <= 1'b0;
         s1_last  <= 1'b0;
         s1_a     <= '0;
         s1_mode  <= ACT_SIGMOID;
      end else if (en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_neg  <= in_data[IN_W-1];
            s1_last <= in_last;
            s1_mode <= mode_in;
`ifdef ACT_TANH_EN
            s1_a    <= (mode_in == ACT_TANH) ? {mag, 1'b0} : {1'b0, mag};
`else
            s1_a    <= mag;
`endif
         end
      end
   end

   act_plan_seg #(
      .A_W     (A_W),
      .IN_FRAC (IN_FRAC),
      .IFRAC   (IFRAC)
   ) u_plan (
      .a (s1_a),
      .f (plan_f)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_neg   <= 1'b0;
         s2_last  <= 1'b0;
         s2_a     <= '0;
         s2_f     <= '0;
         s2_mode  <= ACT_SIGMOID;
      end else if (en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_neg  <= s1_neg;
            s2_last <= s1_last;
            s2_a    <= s1_a;
            s2_f    <= plan_f;
            s2_mode <= s1_mode;
         end
      end
   end

   always_comb begin
      a_u   = V_W'(s2_a) << (IFRAC - IN_FRAC);
      a_v   = signed'(a_u);
      f_v   = signed'(V_W'(s2_f));
      sig_v = s2_neg ? (ONE - f_v) : f_v;
      res   = sig_v;
      case (s2_mode)
         ACT_RELU:  res = s2_neg ? '0 : a_v;
         ACT_IDENT: res = s2_neg ? -a_v : a_v;
`ifdef ACT_TANH_EN
         ACT_TANH:  res = (sig_v <<< 1) - ONE;
`endif
         default:   res = sig_v;
      endcase
      // arithmetic shift floors, so adding half first gives round-half-up
      rnd = (res + HALF) >>> RSH;
      if (rnd > SAT_HI)
         sat = SAT_HI;
      else if (rnd < SAT_LO)
         sat = SAT_LO;
      else
         sat = rnd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (en) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_data <= OUT_W'(sat);
            out_last <= s2_last;
         end
      end
   end

endmodule

// File: tb/tb_act_pipe.sv
// Self-checking bench for act_pipe: directed spec vectors, random mixed-mode
// stream against an arithmetic reference, stall, and mid-flight reset.
module tb_act_pipe;
   import act_pkg::*;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [1:0] in_mode;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;

   act_pipe #(
      .IN_W     (8),
      .IN_FRAC  (4),
      .OUT_W    (8),
      .OUT_FRAC (6)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   typedef struct {
      int   data;
      logic last;
      int   t;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_out   = 0;
   int   cyc     = 0;
   int   drv_exp = 0;
   bit   lat_chk = 0;
   int   rdy_mode = 1;  // 0 hold low, 1 hold high, 2 random

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: inputs in 1/16 units, PLAN evaluated in 1/4096 units, output in 1/64.
   function automatic int model(input int x, input int mode);
      int a, f, s, v, r;
      bit neg;
      neg = (x < 0);
      a   = neg ? -x : x;
`ifdef ACT_TANH_EN
      if (mode == 2) a = 2 * a;
`endif
      if (a >= 80)      f = 4096;
      else if (a >= 38) f = a * 8 + 3456;
      else if (a >= 16) f = a * 32 + 2560;
      else              f = a * 64 + 2048;
      s = neg ? 4096 - f : f;
      case (mode)
         1: v = neg ? 0 : a * 256;
         3: v = neg ? -a * 256 : a * 256;
         2: begin
`ifdef ACT_TANH_EN
            v = 2 * s - 4096;
`else
            v = s;
`endif
         end
         default: v = s;
      endcase
      r = (v + 32) >>> 6;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Handshake monitor: transfers are decided by the values held at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            exp_q.delete();
         end else begin
            if (out_valid && out_ready) begin
               n_out++;
               if (exp_q.size() == 0) begin
                  check("spurious_out", int'(out_valid), 0);
               end else begin
                  e = exp_q.pop_front();
                  check("data", int'($signed(out_data)), e.data);
                  check("last", int'(out_last), int'(e.last));
                  if (lat_chk) check("latency", cyc - e.t, 3);
               end
            end
            if (in_valid && in_ready) exp_q.push_back('{drv_exp, in_last, cyc});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send_beat(input logic [7:0] d, input logic [1:0] m, input logic l,
                            input int exp);
      int k;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      in_last  = l;
      drv_exp  = exp;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!in_ready && k < 200);
      if (!in_ready) check("accept_timeout", int'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   int dir_d[12] = '{0, 8, 16, -16, 127, -48, 24, 32, -128, 16, -16, 0};
   int dir_m[12] = '{0, 0, 0, 0, 0, 1, 1, 1, 3, 2, 2, 2};
`ifdef ACT_TANH_EN
   int dir_e[12] = '{32, 40, 48, 16, 64, 0, 96, 127, -128, 48, -48, 0};
`else
   int dir_e[12] = '{32, 40, 48, 16, 64, 0, 96, 127, -128, 48, 16, 32};
`endif

   initial begin
      int n0, d, m, ea;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_mode  = '0;
      in_last  = 1'b0;
      out_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'($signed(out_data)), 0);
      check("rst_out_last", int'(out_last), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("idle_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;

      // directed spec vectors, no stall, exact latency
      lat_chk = 1;
      for (int i = 0; i < 12; i++)
         send_beat(8'(dir_d[i]), 2'(dir_m[i]), 1'b0, dir_e[i]);
      drain();
      lat_chk = 0;

      // random mixed-mode stream with random backpressure
      rdy_mode = 2;
      n0 = n_out;
      for (int i = 0; i < 20; i++) begin
         d = $urandom_range(0, 255);
         m = $urandom_range(0, 3);
         send_beat(8'(d), 2'(m), (i == 19), model(int'($signed(8'(d))), m));
      end
      drain();
      check("stream_count", n_out - n0, 20);
      rdy_mode = 1;
      @(posedge clk);
      #1;

      // fill the pipe with the output blocked, then stall with a beat pending
      rdy_mode = 0;
      @(posedge clk);
      #1;
      d  = $urandom_range(0, 255);
      ea = model(int'($signed(8'(d))), 0);
      send_beat(8'(d), 2'b00, 1'b0, ea);
      send_beat(8'd40, 2'b01, 1'b0, model(40, 1));
      send_beat(8'd200, 2'b11, 1'b0, model(-56, 3));
      in_valid = 1'b1;
      in_data  = 8'd20;
      in_mode  = 2'b00;
      in_last  = 1'b1;
      drv_exp  = model(20, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_in_ready", int'(in_ready), 0);
         check("stall_hold", int'($signed(out_data)), ea);
      end
      @(posedge clk);
      #1 rdy_mode = 1;
      @(negedge clk);
      check("simul_accept", int'(in_ready), 1);
      check("simul_emit", int'(out_valid), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      drain();

      // reset with three beats in flight
      rdy_mode = 0;
      @(posedge clk);
      #1;
      send_beat(8'd16, 2'b00, 1'b0, model(16, 0));
      send_beat(8'd24, 2'b01, 1'b1, model(24, 1));
      send_beat(8'd240, 2'b11, 1'b0, model(-16, 3));
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("flush_out_valid", int'(out_valid), 0);
      check("flush_out_data", int'($signed(out_data)), 0);
      check("flush_out_last", int'(out_last), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rdy_mode = 1;
      n0 = n_out;
      repeat (10) @(negedge clk);
      check("post_rst_quiet", n_out - n0, 0);
      check("post_rst_in_ready", int'(in_ready), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/act_pipe.md
# act_pipe

Parametrised, pipelined neuron activation unit: takes one signed fixed-point pre-activation per beat and returns sigmoid, ReLU, identity or tanh of it. It replaces the single-shot 8-bit sigmoid lookup with a piecewise-linear (PLAN) shift-add evaluator, selected per beat, behind a valid/ready stream. It sits between the MAC accumulator output and the next layer's input buffer.

## Interface
- IN_W, 8: input width, signed two's complement
- IN_FRAC, 4: input fraction bits; must be ≥3 so 2.375 is representable
- OUT_W, 8: output width, signed two's complement
- OUT_FRAC, 6: output fraction bits
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input beat present
- in_ready  out  1  unit accepts beat this cycle
- in_data  in  IN_W  pre-activation, Q(IN_W-IN_FRAC).IN_FRAC
- in_mode  in  2  00 sigmoid, 01 ReLU, 10 tanh, 11 identity; sampled with beat
- in_last  in  1  end-of-vector marker; passed through unchanged
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  activation, Q(OUT_W-OUT_FRAC).OUT_FRAC
- out_last  out  1  in_last of the same beat

## Operation
- Beat transfers when in_valid && in_ready; result transfers when out_valid && out_ready.
- Stage 1 registers: sign, |x| (IN_W+1 bits, so the most negative input is exact), mode, last. Tanh stores 2|x| (IN_W+2 bits).
- Stage 2: PLAN on a = |x| (or 2|x|): a≥5 → 1.0; 2.375≤a<5 → a/32+0.84375; 1≤a<2.375 → a/8+0.625; a<1 → a/4+0.5. Breakpoint values belong to the upper segment. Internal fraction OUT_FRAC+6 bits; shifts and adds only, no multipliers.
- Stage 3: sigmoid: x<0 → 1−f. Tanh: 2·s−1, where s is the sign-corrected sigmoid of 2x. ReLU: x<0 → 0, else x. Identity: x. Rescale to OUT_FRAC with round-half-up. Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Mode and last travel with the beat; mixed modes back-to-back are legal.

## Timing
- Three register stages; latency exactly 3 cycles from accepted beat to out_valid with no stall.
- Pipeline advance en = !out_valid || out_ready; in_ready = en (combinational from out_ready). All stages hold when en=0.
- Throughput one beat per cycle while out_ready stays high. Bubbles propagate as cleared stage-valid bits.
- A stage's data registers load only when its incoming valid is 1 and en=1.
- Reset: all stage-valid bits 0; out_valid=0, out_data=0, out_last=0; in_ready=1 from the first cycle after reset. In-flight beats are discarded; nothing is emitted after reset deasserts until new beats arrive.
- Simultaneous accept and emit when full with out_ready=1: both occur in the same cycle, no loss, no duplication.
- out_data/out_last stable while out_valid && !out_ready.

## Configuration
- ACT_TANH_EN defined: mode 10 computes tanh as above, with the 2|x| path and the 2s−1 stage.
- ACT_TANH_EN undefined: the doubling path and the 2s−1 logic are removed, and mode 10 returns the sigmoid result. Latency and handshake are unchanged.

## Structure
- Package act_pkg: mode enum (ACT_SIGMOID, ACT_RELU, ACT_TANH, ACT_IDENT), PLAN breakpoints/offsets/shift amounts, internal-fraction constant, width helper functions.
- Sub-module act_plan_seg: combinational segment selector plus shift-add on |x|, instantiated once in stage 2.

## Test plan
Defaults throughout: IN Q4.4, OUT Q2.6; 1.0 = 64 at the output.
- Reset, then sigmoid on in_data 0, 8, 16, −16, 127 → out_data 32, 40, 48, 16, 64, each exactly 3 cycles after accept.
- ReLU on −48, 24, 32 → 0, 96, 127 (saturated); identity on −128 → −128 (saturated).
- Tanh on 16, −16, 0 → 48, −48, 0 with ACT_TANH_EN; the same inputs without the macro → 48, 16, 32.
- Stream 20 beats of mixed modes with out_ready toggling randomly → results in order, none dropped or duplicated, out_last matches the 20th beat only.
- Full pipe, out_ready=0 for 5 cycles → in_ready=0 and out_data held; out_ready=1 with in_valid=1 → accept and emit in the same cycle.
- Assert rst with 3 beats in flight → next cycle out_valid=0, out_data=0; those beats never appear.
